// File: rtl/z80_gpio_bank.sv
// Z80 IO-mapped GPIO bank: NUM_PORTS 8-bit channels with set/clear/toggle writes, all logic on falling phi.
// Define GPIO_IRQ_EN to add per-channel rising-edge interrupt mask/status and the irq output.
module z80_gpio_bank #(
  parameter int         NUM_PORTS = 2,
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter logic [7:0] OUT_RESET = 8'h00
) (
  input  logic                   phi,
  input  logic                   reset_n,
  input  logic [7:0]             a,
  input  logic [7:0]             din,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  output logic [7:0]             dout,
  output logic                   dout_en,
  input  logic [8*NUM_PORTS-1:0] gpio_in,
  output logic [8*NUM_PORTS-1:0] gpio_out,
  output logic                   irq
);

  typedef enum logic [1:0] {WR_IDLE, WR_T1, WR_WAIT} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_WAIT} rd_state_t;

  localparam logic [8:0] END_ADDR = 9'(int'(BASE_ADDR) + 8 * NUM_PORTS);

  wr_state_t wr_state_reg, wr_state_next;
  rd_state_t rd_state_reg, rd_state_next;
  logic      wr_active, rd_active, wr_tick, rd_tick;
  logic      in_range, readable;
  logic [2:0] chan_idx, off;
  logic [7:0] dout_mux;
  logic [8*NUM_PORTS-1:0] rd_bus;

  assign wr_active = !iorq_n && !wr_n;
  assign rd_active = !iorq_n && !rd_n;

  always_ff @(negedge phi or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_reg <= WR_IDLE;
      rd_state_reg <= RD_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
    end
  end

  // Writes commit on the second falling edge so din is stable; WAIT absorbs any wait states.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_tick       = 1'b0;
    rd_state_next = rd_state_reg;
    rd_tick       = 1'b0;
    case (wr_state_reg)
      WR_IDLE: if (wr_active) wr_state_next = WR_T1;
      WR_T1: begin
        if (wr_active) begin
          wr_tick       = 1'b1;
          wr_state_next = WR_WAIT;
        end else begin
          wr_state_next = WR_IDLE;
        end
      end
      WR_WAIT: if (!wr_active) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
    case (rd_state_reg)
      RD_IDLE: begin
        if (rd_active) begin
          rd_tick       = 1'b1;
          rd_state_next = RD_WAIT;
        end
      end
      RD_WAIT: if (!rd_active) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  rd_tick_in_cycle: assert property (@(negedge phi) disable iff (!reset_n) rd_tick |-> rd_active);

  assign in_range = ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  assign chan_idx = 3'((a - BASE_ADDR) >> 3);
  assign off      = a[2:0];

`ifdef GPIO_IRQ_EN
  logic [NUM_PORTS-1:0] irq_vec;
  logic                 irq_reg;

  assign readable = in_range && (off <= 3'd5);

  always_ff @(negedge phi or negedge reset_n) begin
    if (!reset_n) irq_reg <= 1'b0;
    else          irq_reg <= |irq_vec;
  end
  assign irq = irq_reg;
`else
  assign readable = in_range && (off <= 3'd3);
  assign irq      = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
    logic [7:0] out_reg, out_next, sync1_reg, sync2_reg, ch_rd;
    logic       wr_sel;

    assign wr_sel = wr_tick && in_range && (chan_idx == 3'(gi));

    always_comb begin
      out_next = out_reg;
      if (wr_sel) begin
        case (off)
          3'd0:    out_next = din;
          3'd1:    out_next = out_reg | din;
          3'd2:    out_next = out_reg & ~din;
          3'd3:    out_next = out_reg ^ din;
          default: out_next = out_reg;
        endcase
      end
    end

    always_ff @(negedge phi or negedge reset_n) begin
      if (!reset_n) begin
        out_reg   <= OUT_RESET;
        sync1_reg <= 8'h00;
        sync2_reg <= 8'h00;
      end else begin
        out_reg   <= out_next;
        sync1_reg <= gpio_in[8*gi +: 8];
        sync2_reg <= sync1_reg;
      end
    end

    assign gpio_out[8*gi +: 8] = out_reg;

`ifdef GPIO_IRQ_EN
    logic [7:0] mask_reg, mask_next, status_reg, status_next, prev_reg, rise;

    assign rise = sync2_reg & ~prev_reg;

    // Capture is OR-ed in after the W1C so a same-edge rising input keeps its status bit.
    always_comb begin
      mask_next   = mask_reg;
      status_next = status_reg;
      if (wr_sel && off == 3'd4) mask_next = din;
      if (wr_sel && off == 3'd5) status_next = status_reg & ~din;
      status_next = status_next | (rise & mask_reg);
    end

    always_ff @(negedge phi or negedge reset_n) begin
      if (!reset_n) begin
        mask_reg   <= 8'h00;
        status_reg <= 8'h00;
        prev_reg   <= 8'h00;
      end else begin
        mask_reg   <= mask_next;
        status_reg <= status_next;
        prev_reg   <= sync2_reg;
      end
    end

    assign irq_vec[gi] = |(status_reg & mask_reg);

    always_comb begin
      case (off)
        3'd0:          ch_rd = sync2_reg;
        3'd1, 3'd2, 3'd3: ch_rd = out_reg;
        3'd4:          ch_rd = mask_reg;
        3'd5:          ch_rd = status_reg;
        default:       ch_rd = 8'h00;
      endcase
    end
`else
    always_comb begin
      case (off)
        3'd0:          ch_rd = sync2_reg;
        3'd1, 3'd2, 3'd3: ch_rd = out_reg;
        default:       ch_rd = 8'h00;
      endcase
    end
`endif

    assign rd_bus[8*gi +: 8] = ch_rd;
  end

  always_comb begin
    dout_mux = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (chan_idx == 3'(i)) dout_mux = rd_bus[8*i +: 8];
    end
  end

  assign dout_en = rd_active && readable;
  assign dout    = readable ? dout_mux : 8'h00;

endmodule

// File: tb/tb_z80_gpio_bank.sv
// Directed bench for z80_gpio_bank (NUM_PORTS=2, BASE_ADDR=A0, OUT_RESET=C3); bus cycles start on rising phi.
module tb_z80_gpio_bank;
  logic        phi = 1'b1;
  logic        reset_n;
  logic [7:0]  a, din, dout;
  logic        iorq_n, rd_n, wr_n, dout_en, irq;
  logic [15:0] gpio_in, gpio_out;
  int          checks_total  = 0;
  int          checks_passed = 0;
  logic [7:0]  rdata;
  logic        ren;

  z80_gpio_bank #(.NUM_PORTS(2), .BASE_ADDR(8'hA0), .OUT_RESET(8'hC3)) dut (
    .phi(phi), .reset_n(reset_n), .a(a), .din(din), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .dout(dout), .dout_en(dout_en), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .irq(irq)
  );

  always #5 phi = ~phi;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("ok   %s: %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data, input int waits);
    @(posedge phi);
    a = addr; din = data; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (2 + waits) @(posedge phi);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge phi);
    #1;
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] data, output logic en);
    @(posedge phi);
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    data = dout; en = dout_en;
    @(posedge phi);
    iorq_n = 1'b1; rd_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; a = 8'h00; din = 8'h00; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    gpio_in = 16'h0000;
    repeat (2) @(posedge phi);
    #1;
    check("reset_gpio_out", gpio_out, 16'hC3C3);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    check("reset_dout_en", {15'd0, dout_en}, 16'h0000);
    @(posedge phi);
    reset_n = 1'b1;
    repeat (2) @(posedge phi);

    // Write 5A to A8 held for two extra wait states: lands on the 2nd falling edge only.
    a = 8'hA8; din = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge phi); #1;
    check("wr_t1_no_update", {8'h00, gpio_out[15:8]}, 16'h00C3);
    @(posedge phi); #1;
    check("wr_2nd_edge", {8'h00, gpio_out[15:8]}, 16'h005A);
    repeat (2) @(posedge phi); #1;
    check("wr_wait_hold", {8'h00, gpio_out[15:8]}, 16'h005A);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge phi);
    io_read(8'hA9, rdata, ren);
    check("rd_A9_en", {15'd0, ren}, 16'h0001);
    check("rd_A9_data", {8'h00, rdata}, 16'h005A);

    // Toggle with 3 wait states must flip exactly once: 5A ^ FF = A5.
    io_write(8'hAB, 8'hFF, 3);
    check("toggle_once", {8'h00, gpio_out[15:8]}, 16'h00A5);

    io_write(8'hA0, 8'hF0, 0);
    check("wr_A0_F0", {8'h00, gpio_out[7:0]}, 16'h00F0);
    io_write(8'hA1, 8'h0F, 1);
    check("set_0F", {8'h00, gpio_out[7:0]}, 16'h00FF);
    io_write(8'hA2, 8'h81, 0);
    check("clear_81", {8'h00, gpio_out[7:0]}, 16'h007E);
    io_write(8'hA3, 8'hFF, 2);
    check("toggle_FF", {8'h00, gpio_out[7:0]}, 16'h0081);
    check("ch1_untouched", {8'h00, gpio_out[15:8]}, 16'h00A5);

    // Input synchronizer: offset-0 read shows new pins only after two falling edges.
    @(posedge phi);
    gpio_in = 16'h00A5; a = 8'hA0; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("sync_0_edges", {7'd0, dout_en, dout}, 16'h0100);
    @(posedge phi); #1;
    check("sync_1_edge", {7'd0, dout_en, dout}, 16'h0100);
    @(posedge phi); #1;
    check("sync_2_edges", {7'd0, dout_en, dout}, 16'h01A5);
    iorq_n = 1'b1; rd_n = 1'b1;

    io_read(8'hB0, rdata, ren);
    check("rd_B0_unmapped", {15'd0, ren}, 16'h0000);
    io_read(8'hA6, rdata, ren);
    check("rd_A6_undecoded", {15'd0, ren}, 16'h0000);
    io_read(8'h9F, rdata, ren);
    check("rd_9F_below_base", {15'd0, ren}, 16'h0000);
    io_write(8'hA6, 8'h55, 0);
    io_write(8'hA7, 8'h00, 0);
    io_write(8'hB0, 8'h00, 0);
    io_write(8'hAE, 8'h00, 0);
    check("wr_undecoded_no_change", gpio_out, 16'hA581);

    @(posedge phi);
    gpio_in = 16'hFFFF;
    repeat (6) @(posedge phi); #1;
    check("irq_masked_edges", {15'd0, irq}, 16'h0000);
`ifndef GPIO_IRQ_EN
    io_read(8'hA4, rdata, ren);
    check("rd_A4_no_irq_build", {15'd0, ren}, 16'h0000);
    io_read(8'hAD, rdata, ren);
    check("rd_AD_no_irq_build", {15'd0, ren}, 16'h0000);
    io_write(8'hA4, 8'hFF, 0);
    io_write(8'hA5, 8'hFF, 0);
    repeat (3) @(posedge phi); #1;
    check("irq_tied_low", {15'd0, irq}, 16'h0000);
    check("wr_A4_A5_no_change", gpio_out, 16'hA581);
`endif

    // Strobes dropped while in T1: no write.
    @(posedge phi);
    a = 8'hA0; din = 8'h00; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge phi);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(posedge phi); #1;
    check("t1_abort_no_write", gpio_out, 16'hA581);

    // Reset asserted during T1 of a write of 33 to A0.
    @(posedge phi);
    a = 8'hA0; din = 8'h33; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge phi);
    reset_n = 1'b0;
    #1;
    check("reset_mid_write_out", gpio_out, 16'hC3C3);
    check("reset_mid_write_irq", {15'd0, irq}, 16'h0000);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(posedge phi);
    reset_n = 1'b1;
    repeat (4) @(posedge phi); #1;
    check("no_write_after_reset", gpio_out, 16'hC3C3);
    io_write(8'hA0, 8'h33, 0);
    check("fresh_write_after_reset", gpio_out, 16'hC333);

`ifdef GPIO_IRQ_EN
    io_read(8'hA5, rdata, ren);
    check("status_after_reset_mask0", {7'd0, ren, rdata}, 16'h0100);
    @(posedge phi);
    gpio_in = 16'h0000;
    repeat (4) @(posedge phi);
    io_write(8'hA4, 8'h08, 0);
    io_read(8'hA4, rdata, ren);
    check("rd_mask", {7'd0, ren, rdata}, 16'h0108);
    @(posedge phi);
    gpio_in = 16'h0008;
    repeat (5) @(posedge phi); #1;
    check("irq_on_edge", {15'd0, irq}, 16'h0001);
    io_read(8'hA5, rdata, ren);
    check("status_08", {7'd0, ren, rdata}, 16'h0108);
    io_write(8'hA5, 8'h08, 0);
    check("irq_after_w1c", {15'd0, irq}, 16'h0000);
    io_read(8'hA5, rdata, ren);
    check("status_cleared", {7'd0, ren, rdata}, 16'h0100);
    @(posedge phi);
    gpio_in = 16'h0000;
    repeat (4) @(posedge phi);
    // Input rises one edge before the write so capture lands on the W1C edge.
    @(posedge phi);
    gpio_in = 16'h0008;
    io_write(8'hA5, 8'h08, 0);
    io_read(8'hA5, rdata, ren);
    check("capture_beats_w1c", {7'd0, ren, rdata}, 16'h0108);
    check("irq_capture_beats_w1c", {15'd0, irq}, 16'h0001);
    io_write(8'hA4, 8'h00, 0);
    check("irq_masked_off", {15'd0, irq}, 16'h0000);
    io_read(8'hA5, rdata, ren);
    check("mask_keeps_status", {7'd0, ren, rdata}, 16'h0108);
    io_write(8'hA4, 8'h08, 0);
    check("irq_unmask_pending", {15'd0, irq}, 16'h0001);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
